// File: rtl/axi4_burst_master_if.sv
// AXI4 master-port bundle (AW/W/B/AR/R) used between axi4_burst_master and the NoC ingress.
// Widths follow the engine parameters so one instance serves any bus configuration.
interface axi4_burst_master_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int ID_W   = 4,
  parameter int LEN_W  = 8
);
  logic              M_AWVALID;
  logic              M_AWREADY;
  logic [ADDR_W-1:0] M_AWADDR;
  logic [LEN_W-1:0]  M_AWLEN;
  logic [2:0]        M_AWSIZE;
  logic [1:0]        M_AWBURST;
  logic [ID_W-1:0]   M_AWID;

  logic                M_WVALID;
  logic                M_WREADY;
  logic [DATA_W-1:0]   M_WDATA;
  logic [DATA_W/8-1:0] M_WSTRB;
  logic                M_WLAST;

  logic            M_BVALID;
  logic            M_BREADY;
  logic [1:0]      M_BRESP;
  logic [ID_W-1:0] M_BID;

  logic              M_ARVALID;
  logic              M_ARREADY;
  logic [ADDR_W-1:0] M_ARADDR;
  logic [LEN_W-1:0]  M_ARLEN;
  logic [2:0]        M_ARSIZE;
  logic [1:0]        M_ARBURST;
  logic [ID_W-1:0]   M_ARID;

  logic              M_RVALID;
  logic              M_RREADY;
  logic [DATA_W-1:0] M_RDATA;
  logic [1:0]        M_RRESP;
  logic              M_RLAST;
  logic [ID_W-1:0]   M_RID;

  modport master (
    output M_AWVALID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWID,
    input  M_AWREADY,
    output M_WVALID, M_WDATA, M_WSTRB, M_WLAST,
    input  M_WREADY,
    input  M_BVALID, M_BRESP, M_BID,
    output M_BREADY,
    output M_ARVALID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARID,
    input  M_ARREADY,
    input  M_RVALID, M_RDATA, M_RRESP, M_RLAST, M_RID,
    output M_RREADY
  );

  modport slave (
    input  M_AWVALID, M_AWADDR, M_AWLEN, M_AWSIZE, M_AWBURST, M_AWID,
    output M_AWREADY,
    input  M_WVALID, M_WDATA, M_WSTRB, M_WLAST,
    output M_WREADY,
    output M_BVALID, M_BRESP, M_BID,
    input  M_BREADY,
    input  M_ARVALID, M_ARADDR, M_ARLEN, M_ARSIZE, M_ARBURST, M_ARID,
    output M_ARREADY,
    output M_RVALID, M_RDATA, M_RRESP, M_RLAST, M_RID,
    input  M_RREADY
  );
endinterface

// File: rtl/axi4_burst_master.sv
// Single-outstanding AXI4 burst master: turns command + data streams into AXI4 read/write
// bursts, screens illegal bursts, and reports one merged completion per command.
module axi4_burst_master #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int ID_W      = 4,
  parameter int LEN_W     = 8,
  parameter bit ERR_ON_4K = 1'b1
) (
  input  logic                ACLK,
  input  logic                ARESETn,

  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [2:0]          cmd_size,
  input  logic [1:0]          cmd_burst,
  input  logic [ID_W-1:0]     cmd_id,

  input  logic                wd_valid,
  output logic                wd_ready,
  input  logic [DATA_W-1:0]   wd_data,
  input  logic [DATA_W/8-1:0] wd_strb,

  output logic                rd_valid,
  input  logic                rd_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_last,

  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [1:0]          rsp_resp,
  output logic [ID_W-1:0]     rsp_id,
  output logic                rsp_err,

  axi4_burst_master_if.master axi
);

  localparam logic [2:0] MAX_SIZE = 3'($clog2(DATA_W/8));

  typedef enum logic [2:0] {IDLE, CHK, AW, W, B, AR, R, RSP} state_t;

  state_t state;

  logic              write_q;
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  len_q;
  logic [2:0]        size_q;
  logic [1:0]        burst_q;
  logic [ID_W-1:0]   id_q;
  logic [LEN_W-1:0]  beat;
  logic [1:0]        resp_q;
  logic              err_q;

  logic cmd_ready_q;
  logic aw_valid_q;
  logic ar_valid_q;
  logic b_ready_q;
  logic rsp_valid_q;

  logic [7:0]  size_mask;
  logic [23:0] span;
  logic [23:0] end_off;
  logic        wrap_len_ok;
  logic        illegal;
  logic        in_w;
  logic        in_r;
  logic        w_fire;
  logic        r_fire;
  logic        last_beat;
  logic [1:0]  merged_resp;

  // Burst screening; the 4 KB end offset is kept 24 bits wide so 256 beats of 128 bytes cannot wrap.
  always_comb begin
    size_mask   = (8'd1 << size_q) - 8'd1;
    span        = ({{(24-LEN_W){1'b0}}, len_q} + 24'd1) << size_q;
    end_off     = {12'd0, addr_q[11:0]} + span;
    wrap_len_ok = (len_q == LEN_W'(1)) || (len_q == LEN_W'(3)) ||
                  (len_q == LEN_W'(7)) || (len_q == LEN_W'(15));
    illegal     = 1'b0;
    if (size_q > MAX_SIZE)
      illegal = 1'b1;
    if (burst_q == 2'b11)
      illegal = 1'b1;
    if (burst_q == 2'b10 && (!wrap_len_ok || (addr_q[7:0] & size_mask) != 8'd0))
      illegal = 1'b1;
    if (ERR_ON_4K && burst_q == 2'b01 && end_off > 24'd4096)
      illegal = 1'b1;
  end

  assign in_w        = (state == W);
  assign in_r        = (state == R);
  assign w_fire      = in_w & wd_valid & axi.M_WREADY;
  assign r_fire      = in_r & axi.M_RVALID & rd_ready;
  assign last_beat   = (beat == len_q);
  assign merged_resp = (axi.M_RRESP > resp_q) ? axi.M_RRESP : resp_q;

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_resp  = resp_q;
  assign rsp_id    = id_q;
  assign rsp_err   = err_q;

  assign axi.M_AWVALID = aw_valid_q;
  assign axi.M_AWADDR  = addr_q;
  assign axi.M_AWLEN   = len_q;
  assign axi.M_AWSIZE  = size_q;
  assign axi.M_AWBURST = burst_q;
  assign axi.M_AWID    = id_q;

  assign axi.M_ARVALID = ar_valid_q;
  assign axi.M_ARADDR  = addr_q;
  assign axi.M_ARLEN   = len_q;
  assign axi.M_ARSIZE  = size_q;
  assign axi.M_ARBURST = burst_q;
  assign axi.M_ARID    = id_q;

  // Data beats stream straight through while the owning phase is active.
  assign axi.M_WVALID = in_w & wd_valid;
  assign axi.M_WDATA  = wd_data;
  assign axi.M_WSTRB  = wd_strb;
  assign axi.M_WLAST  = in_w & last_beat;
  assign wd_ready     = in_w & axi.M_WREADY;

  assign axi.M_BREADY = b_ready_q;

  assign axi.M_RREADY = in_r & rd_ready;
  assign rd_valid     = in_r & axi.M_RVALID;
  assign rd_data      = axi.M_RDATA;
  assign rd_last      = in_r & axi.M_RLAST;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state       <= IDLE;
      cmd_ready_q <= 1'b0;
      aw_valid_q  <= 1'b0;
      ar_valid_q  <= 1'b0;
      b_ready_q   <= 1'b0;
      rsp_valid_q <= 1'b0;
      write_q     <= 1'b0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      id_q        <= '0;
      beat        <= '0;
      resp_q      <= '0;
      err_q       <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          cmd_ready_q <= 1'b1;
          if (cmd_valid && cmd_ready_q) begin
            cmd_ready_q <= 1'b0;
            write_q     <= cmd_write;
            addr_q      <= cmd_addr;
            len_q       <= cmd_len;
            size_q      <= cmd_size;
            burst_q     <= cmd_burst;
            id_q        <= cmd_id;
            beat        <= '0;
            resp_q      <= 2'b00;
            err_q       <= 1'b0;
            state       <= CHK;
          end
        end
        CHK: begin
          if (illegal) begin
            resp_q      <= 2'b10;
            err_q       <= 1'b1;
            rsp_valid_q <= 1'b1;
            state       <= RSP;
          end else if (write_q) begin
            aw_valid_q <= 1'b1;
            state      <= AW;
          end else begin
            ar_valid_q <= 1'b1;
            state      <= AR;
          end
        end
        AW: begin
          if (axi.M_AWREADY) begin
            aw_valid_q <= 1'b0;
            beat       <= '0;
            state      <= W;
          end
        end
        W: begin
          if (w_fire) begin
            if (last_beat) begin
              b_ready_q <= 1'b1;
              state     <= B;
            end else begin
              beat <= beat + LEN_W'(1);
            end
          end
        end
        B: begin
          if (axi.M_BVALID) begin
            resp_q      <= axi.M_BRESP;
            err_q       <= err_q | (axi.M_BID != id_q);
            b_ready_q   <= 1'b0;
            rsp_valid_q <= 1'b1;
            state       <= RSP;
          end
        end
        AR: begin
          if (axi.M_ARREADY) begin
            ar_valid_q <= 1'b0;
            beat       <= '0;
            state      <= R;
          end
        end
        // RLAST must coincide exactly with the final counted beat; either disagreement flags an error.
        R: begin
          if (r_fire) begin
            resp_q <= merged_resp;
            if ((axi.M_RID != id_q) || (axi.M_RLAST != last_beat))
              err_q <= 1'b1;
            if (axi.M_RLAST || last_beat) begin
              rsp_valid_q <= 1'b1;
              state       <= RSP;
            end else begin
              beat <= beat + LEN_W'(1);
            end
          end
        end
        RSP: begin
          if (rsp_ready) begin
            rsp_valid_q <= 1'b0;
            cmd_ready_q <= 1'b1;
            state       <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi4_burst_master.sv
// Randomised bench for axi4_burst_master: a cycle-level source/slave drives both sides while
// expected completions come from the burst legality and response-merge rules.
module tb_axi4_burst_master;
  localparam int ADDR_W = 32;
  localparam int DATA_W = 32;
  localparam int ID_W   = 4;
  localparam int LEN_W  = 8;
  localparam bit ERR_ON_4K = 1'b1;

  logic ACLK = 1'b0;
  logic ARESETn = 1'b0;

  logic        cmd_valid, cmd_ready, cmd_write;
  logic [31:0] cmd_addr;
  logic [7:0]  cmd_len;
  logic [2:0]  cmd_size;
  logic [1:0]  cmd_burst;
  logic [3:0]  cmd_id;
  logic        wd_valid, wd_ready;
  logic [31:0] wd_data;
  logic [3:0]  wd_strb;
  logic        rd_valid, rd_ready, rd_last;
  logic [31:0] rd_data;
  logic        rsp_valid, rsp_ready, rsp_err;
  logic [1:0]  rsp_resp;
  logic [3:0]  rsp_id;

  axi4_burst_master_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W)) bus ();

  axi4_burst_master #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W), .LEN_W(LEN_W), .ERR_ON_4K(ERR_ON_4K)
  ) dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
    .cmd_len(cmd_len), .cmd_size(cmd_size), .cmd_burst(cmd_burst), .cmd_id(cmd_id),
    .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data), .wd_strb(wd_strb),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_resp(rsp_resp), .rsp_id(rsp_id),
    .rsp_err(rsp_err),
    .axi(bus)
  );

  always #5 ACLK = ~ACLK;

  int compared = 0;
  int mismatched = 0;
  int stall_pct = 30;

  logic [31:0] wdata [0:255];
  logic [3:0]  wstrb [0:255];
  logic [31:0] rdata [0:255];
  logic [1:0]  rresp [0:255];

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    compared++;
    if (observed !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: observed 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic bit go();
    return ($urandom_range(0, 99) >= stall_pct);
  endfunction

  function automatic int idx(input int b);
    return (b > 255) ? 255 : b;
  endfunction

  // Legality straight from the AXI rules, in plain byte arithmetic for a 4-byte bus.
  function automatic bit is_legal(input logic [31:0] addr, input int len, input int size, input int burst);
    int bytes_per_beat = 1 << size;
    if (bytes_per_beat > DATA_W / 8) return 1'b0;
    if (burst == 3) return 1'b0;
    if (burst == 2 && !(len == 1 || len == 3 || len == 7 || len == 15)) return 1'b0;
    if (burst == 2 && (addr % bytes_per_beat) != 0) return 1'b0;
    if (ERR_ON_4K && burst == 1 && (addr % 4096) + (len + 1) * bytes_per_beat > 4096) return 1'b0;
    return 1'b1;
  endfunction

  task automatic fill_random();
    for (int k = 0; k < 256; k++) begin
      wdata[k] = $urandom;
      wstrb[k] = 4'($urandom);
      rdata[k] = $urandom;
      rresp[k] = 2'($urandom);
    end
  endtask

  task automatic idle_inputs();
    cmd_valid = 1'b0; wd_valid = 1'b0; rd_ready = 1'b0; rsp_ready = 1'b0;
    bus.M_AWREADY = 1'b0; bus.M_WREADY = 1'b0; bus.M_BVALID = 1'b0; bus.M_ARREADY = 1'b0;
    bus.M_RVALID = 1'b0; bus.M_RLAST = 1'b0;
  endtask

  // One command end to end; rlast_beat < 0 means the slave never raises RLAST.
  task automatic applyStimulus(input bit wr, input logic [31:0] addr, input int len, input int size,
                               input int burst, input int id, input logic [1:0] bresp, input int bid,
                               input int rid, input int rlast_beat, input int reset_at_wbeat);
    bit legal = is_legal(addr, len, size, burst);
    logic [1:0] exp_resp = 2'b00;
    bit exp_err = 1'b0;
    int exp_rbeats = len + 1;
    int accept_cyc = -1, addr_cyc = -1, rsp_cyc = -1;
    int wbeat = 0, rbeat = 0, addr_hs = 0;
    bit accepted = 0, addr_done = 0, b_done = 0, done = 0, aborted = 0;
    bit busy_ready_seen = 0, stray_seen = 0, w_early = 0, bus_on_illegal = 0;
    bit bvalid_on = 0, rvalid_on = 0;

    if (!legal) begin
      exp_resp = 2'b10; exp_err = 1'b1;
    end else if (wr) begin
      exp_resp = bresp; exp_err = (bid != id);
    end else begin
      if (rlast_beat >= 0 && rlast_beat < len) exp_rbeats = rlast_beat + 1;
      exp_err = (rid != id) || (rlast_beat != len);
      for (int k = 0; k < exp_rbeats; k++)
        if (rresp[k] > exp_resp) exp_resp = rresp[k];
    end

    idle_inputs();
    cmd_write = wr; cmd_addr = addr; cmd_len = 8'(len); cmd_size = 3'(size);
    cmd_burst = 2'(burst); cmd_id = 4'(id);

    for (int cyc = 0; cyc < 3000 && !done && !aborted; cyc++) begin
      cmd_valid = !accepted && (cmd_valid || go());
      wd_valid  = wr && (wbeat <= len) && (wd_valid || go() || reset_at_wbeat == wbeat);
      wd_data   = wdata[idx(wbeat)];
      wd_strb   = wstrb[idx(wbeat)];
      bus.M_AWREADY = go();
      bus.M_WREADY  = go() || (reset_at_wbeat >= 0);
      bus.M_ARREADY = go();
      rd_ready  = go();
      rsp_ready = go();
      if (wr) begin
        bvalid_on = (wbeat > len) && !b_done && (bvalid_on || go());
        bus.M_BVALID = bvalid_on;
        bus.M_RVALID = 1'($urandom);
      end else begin
        rvalid_on = addr_done && (rbeat <= len) && (rvalid_on || go());
        bus.M_RVALID = rvalid_on;
        bus.M_BVALID = 1'($urandom);
      end
      bus.M_BRESP = bresp; bus.M_BID = 4'(bid);
      bus.M_RDATA = rdata[idx(rbeat)]; bus.M_RRESP = rresp[idx(rbeat)];
      bus.M_RLAST = (rbeat == rlast_beat); bus.M_RID = 4'(rid);
      #1;
      if (reset_at_wbeat >= 0 && wbeat == reset_at_wbeat && bus.M_WVALID) begin
        ARESETn = 1'b0;
        #1;
        checkOutput("reset_drop", {62'd0, bus.M_WVALID, bus.M_AWVALID} | {62'd0, rsp_valid, cmd_ready}, 64'd0);
        checkOutput("reset_drop_ready", {62'd0, bus.M_BREADY, wd_ready}, 64'd0);
        aborted = 1;
      end else begin
        if (accepted && cmd_ready) busy_ready_seen = 1;
        if ((wr && bus.M_RREADY) || (!wr && bus.M_BREADY)) stray_seen = 1;
        if (bus.M_WVALID && !addr_done) w_early = 1;
        if (!legal && (bus.M_AWVALID || bus.M_ARVALID)) bus_on_illegal = 1;
        if ((bus.M_AWVALID || bus.M_ARVALID) && addr_cyc < 0) addr_cyc = cyc;
        if (rsp_valid && rsp_cyc < 0) rsp_cyc = cyc;
        if (cmd_valid && cmd_ready) begin accepted = 1; accept_cyc = cyc; end
        if (bus.M_AWVALID && bus.M_AWREADY) begin
          checkOutput("aw_fields", 64'({bus.M_AWADDR, bus.M_AWLEN, bus.M_AWSIZE, bus.M_AWBURST, bus.M_AWID}),
                      64'({addr, 8'(len), 3'(size), 2'(burst), 4'(id)}));
          addr_done = 1; addr_hs++;
        end
        if (bus.M_ARVALID && bus.M_ARREADY) begin
          checkOutput("ar_fields", 64'({bus.M_ARADDR, bus.M_ARLEN, bus.M_ARSIZE, bus.M_ARBURST, bus.M_ARID}),
                      64'({addr, 8'(len), 3'(size), 2'(burst), 4'(id)}));
          addr_done = 1; addr_hs++;
        end
        if (bus.M_WVALID && bus.M_WREADY) begin
          checkOutput("w_beat", 64'({bus.M_WDATA, bus.M_WSTRB}), 64'({wdata[idx(wbeat)], wstrb[idx(wbeat)]}));
          checkOutput("w_last", 64'(bus.M_WLAST), 64'(wbeat == len));
          wbeat++;
        end
        if (bus.M_BVALID && bus.M_BREADY && wr) b_done = 1;
        if (bus.M_RVALID && bus.M_RREADY) begin
          checkOutput("rd_beat", 64'({rd_valid, rd_data, rd_last}),
                      64'({1'b1, rdata[idx(rbeat)], 1'(rbeat == rlast_beat)}));
          rbeat++;
          rvalid_on = 0;
        end
        if (rsp_valid && rsp_ready) begin
          checkOutput("rsp", 64'({rsp_resp, rsp_id, rsp_err}), 64'({exp_resp, 4'(id), exp_err}));
          done = 1;
        end
      end
      @(negedge ACLK);
    end

    if (aborted) begin
      idle_inputs();
      repeat (2) @(negedge ACLK);
      ARESETn = 1'b1;
      rsp_ready = 1'b1;
      for (int k = 0; k < 6; k++) begin
        #1;
        if (k == 5) checkOutput("no_rsp_after_abort", 64'(rsp_valid | bus.M_AWVALID | bus.M_WVALID), 64'd0);
        @(negedge ACLK);
      end
      idle_inputs();
      return;
    end

    checkOutput("txn_done", 64'(done), 64'd1);
    checkOutput("busy_cmd_ready", 64'(busy_ready_seen), 64'd0);
    checkOutput("stray_accept", 64'(stray_seen), 64'd0);
    checkOutput("w_before_aw", 64'(w_early), 64'd0);
    if (legal) begin
      checkOutput("addr_latency", 64'(addr_cyc - accept_cyc), 64'd2);
      checkOutput("addr_count", 64'(addr_hs), 64'd1);
      if (wr) checkOutput("w_count", 64'(wbeat), 64'(len + 1));
      else    checkOutput("r_count", 64'(rbeat), 64'(exp_rbeats));
    end else begin
      checkOutput("illegal_rsp_latency", 64'(rsp_cyc - accept_cyc), 64'd2);
      checkOutput("illegal_no_bus", 64'(bus_on_illegal), 64'd0);
    end
    idle_inputs();
    if (done) begin
      #1;
      checkOutput("cmd_ready_turnaround", 64'(cmd_ready), 64'd1);
    end
    @(negedge ACLK);
  endtask

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0; cmd_size = '0; cmd_burst = '0; cmd_id = '0;
    wd_data = '0; wd_strb = '0;
    bus.M_BRESP = '0; bus.M_BID = '0; bus.M_RDATA = '0; bus.M_RRESP = '0; bus.M_RID = '0;
    idle_inputs();
    ARESETn = 1'b0;
    repeat (3) @(negedge ACLK);
    #1;
    checkOutput("reset_valid_ready",
                64'({cmd_ready, bus.M_AWVALID, bus.M_WVALID, bus.M_BREADY, bus.M_ARVALID, bus.M_RREADY, wd_ready, rd_valid}),
                64'd0);
    checkOutput("reset_rsp", 64'({rsp_valid, rsp_resp, rsp_id, rsp_err}), 64'd0);
    @(negedge ACLK);
    ARESETn = 1'b1;

    stall_pct = 0;
    fill_random();
    for (int k = 0; k < 4; k++) begin wdata[k] = 32'hA0 + 32'(k); wstrb[k] = 4'hF; end
    applyStimulus(1, 32'h1000, 3, 2, 1, 5, 2'b00, 5, 5, 3, -1);

    stall_pct = 40;
    fill_random();
    for (int k = 0; k < 8; k++) rresp[k] = 2'b00;
    rresp[5] = 2'b10;
    applyStimulus(0, 32'h2008, 7, 2, 2, 3, 2'b00, 3, 3, 7, -1);

    applyStimulus(1, 32'h0FF8, 3, 2, 1, 1, 2'b00, 1, 1, 3, -1);
    applyStimulus(0, 32'h3000, 4, 2, 2, 2, 2'b00, 2, 2, 4, -1);
    applyStimulus(0, 32'h3000, 1, 3, 1, 2, 2'b00, 2, 2, 1, -1);

    fill_random();
    applyStimulus(0, 32'h4000, 3, 2, 1, 4, 2'b00, 4, 4, 1, -1);
    applyStimulus(0, 32'h4100, 3, 2, 1, 2, 2'b00, 2, 6, 3, -1);

    fill_random();
    applyStimulus(1, 32'h5000, 7, 2, 1, 7, 2'b00, 7, 7, 7, 2);
    fill_random();
    applyStimulus(0, 32'h6000, 3, 2, 1, 9, 2'b00, 9, 9, 3, -1);

    stall_pct = 30;
    for (int t = 0; t < 40; t++) begin
      bit wr = 1'($urandom);
      int size = ($urandom_range(0, 9) == 0) ? 3 : $urandom_range(0, 2);
      int burst = $urandom_range(0, 3);
      int len = $urandom_range(0, 15);
      int id = $urandom_range(0, 15);
      int bid = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : id;
      int rid = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 15) : id;
      int rl = len;
      logic [31:0] addr = $urandom;
      if ($urandom_range(0, 2) == 0) addr[11:0] = 12'hFC0 + 12'($urandom_range(0, 63));
      if ($urandom_range(0, 1) == 0) addr = addr & ~((32'd1 << size) - 32'd1);
      case ($urandom_range(0, 9))
        0: rl = (len > 0) ? $urandom_range(0, len - 1) : len;
        1: rl = -1;
        default: rl = len;
      endcase
      fill_random();
      applyStimulus(wr, addr, len, size, burst, id, 2'($urandom), bid, rid, rl, -1);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
